// File: rtl/mult_seq_param.sv
`default_nettype none
// ============================================================================
// Module   : mult_seq_param
// Brief    : Sequential shift-add multiplier, configurable width and radix,
//            signed/unsigned per operation, full 2*WIDTH product plus overflow.
// Revision : 1.0 - initial release
// ============================================================================
module mult_seq_param #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    input  logic             doMult,
    output logic             busy,
    output logic [WIDTH-1:0] out_hi,
    output logic [WIDTH-1:0] out_lo,
    output logic             out_ovf,
    output logic             mult_done
);

    localparam int N   = WIDTH / BITS_PER_CYCLE;
    localparam int CW  = $clog2(N + 1);
    localparam int BPC = BITS_PER_CYCLE;
    localparam int AW  = 2 * WIDTH + BPC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic               neg_q, neg_d;
    logic               signed_q, signed_d;
    logic [WIDTH-1:0]   out_hi_q, out_hi_d;
    logic [WIDTH-1:0]   out_lo_q, out_lo_d;
    logic               out_ovf_q, out_ovf_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]       w_a_mag;
    logic [WIDTH-1:0]       w_b_mag;
    logic [WIDTH+BPC-1:0]   w_partial;
    logic [WIDTH+BPC-1:0]   w_upper_sum;
    logic [2*WIDTH-1:0]     w_product;

    // Datapath: magnitudes, one radix digit of partial product, final sign fix
    always_comb begin
        // Most-negative input negates to itself, which is its correct unsigned magnitude
        w_a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
        w_b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;
        w_partial   = {{BPC{1'b0}}, mcand_q} * {{WIDTH{1'b0}}, mplier_q[BPC-1:0]};
        w_upper_sum = acc_q[AW-1:WIDTH] + w_partial;
        w_product   = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        signed_d  = signed_q;
        out_hi_d  = out_hi_q;
        out_lo_d  = out_lo_q;
        out_ovf_d = out_ovf_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (doMult) begin
                    mcand_d  = w_a_mag;
                    mplier_d = w_b_mag;
                    neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    signed_d = is_signed;
                    acc_d    = '0;
                    count_d  = CW'(N);
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d    = {w_upper_sum, acc_q[WIDTH-1:0]} >> BPC;
                mplier_d = mplier_q >> BPC;
                count_d  = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                out_hi_d  = w_product[2*WIDTH-1:WIDTH];
                out_lo_d  = w_product[WIDTH-1:0];
                out_ovf_d = signed_q ? (w_product[2*WIDTH-1:WIDTH] != {WIDTH{w_product[WIDTH-1]}})
                                     : (w_product[2*WIDTH-1:WIDTH] != '0);
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            signed_q  <= 1'b0;
            out_hi_q  <= '0;
            out_lo_q  <= '0;
            out_ovf_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            signed_q  <= signed_d;
            out_hi_q  <= out_hi_d;
            out_lo_q  <= out_lo_d;
            out_ovf_q <= out_ovf_d;
            done_q    <= done_d;
        end
    end

    assign busy      = (state_q != ST_IDLE) || done_q;
    assign out_hi    = out_hi_q;
    assign out_lo    = out_lo_q;
    assign out_ovf   = out_ovf_q;
    assign mult_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_seq_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_seq_param
// Brief    : Directed bench for mult_seq_param, radix-1 and radix-4 instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_seq_param;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        is_signed = 1'b0;
    logic        do1 = 1'b0;
    logic        do4 = 1'b0;

    logic        busy1, ovf1, done1;
    logic [31:0] hi1, lo1;
    logic        busy4, ovf4, done4;
    logic [31:0] hi4, lo4;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mult_seq_param #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .a(a), .b(b), .is_signed(is_signed),
        .doMult(do1), .busy(busy1), .out_hi(hi1), .out_lo(lo1),
        .out_ovf(ovf1), .mult_done(done1)
    );

    mult_seq_param #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .a(a), .b(b), .is_signed(is_signed),
        .doMult(do4), .busy(busy4), .out_hi(hi4), .out_lo(lo4),
        .out_ovf(ovf4), .mult_done(done4)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Pulses doMult for one edge; returns 1 time unit after the start edge
    task automatic start_op(input bit sel, input logic [31:0] av, input logic [31:0] bv, input logic sg);
        @(negedge clk);
        a = av; b = bv; is_signed = sg;
        if (sel) do4 = 1'b1; else do1 = 1'b1;
        @(posedge clk);
        #1;
        do1 = 1'b0;
        do4 = 1'b0;
    endtask

    task automatic wait_done(input bit sel, output int lat);
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (sel ? done4 : done1) break;
        end
    endtask

    task automatic run1(input string tag, input logic [31:0] av, input logic [31:0] bv, input logic sg,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic eovf);
        int lat;
        start_op(1'b0, av, bv, sg);
        wait_done(1'b0, lat);
        check_eq({tag, "_lat"}, 64'(lat), 64'd33);
        check_eq({tag, "_hi"}, 64'(hi1), 64'(ehi));
        check_eq({tag, "_lo"}, 64'(lo1), 64'(elo));
        check_eq({tag, "_ovf"}, 64'(ovf1), 64'(eovf));
    endtask

    initial begin
        int lat;
        int seen_done;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 64'({busy1, busy4}), 64'd0);
        check_eq("rst_out", {hi1, lo1}, 64'd0);
        check_eq("rst_flags", 64'({ovf1, done1, ovf4, done4}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Radix-4 instance first, before the shared reset is exercised
        start_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b0);
        wait_done(1'b1, lat);
        check_eq("r4_lat", 64'(lat), 64'd9);
        check_eq("r4_prod", {hi4, lo4}, 64'hFFFF_FFEF_0000_0010);
        check_eq("r4_ovf", 64'(ovf4), 64'd1);
        start_op(1'b1, 32'hFFFF_FFFD, 32'd5, 1'b1);
        wait_done(1'b1, lat);
        check_eq("r4_neg", {hi4, lo4}, 64'hFFFF_FFFF_FFFF_FFF1);
        check_eq("r4_neg_ovf", 64'(ovf4), 64'd0);

        run1("u2x5",  32'd2,         32'd5,         1'b0, 32'h0,         32'd10,        1'b0);
        run1("uFF",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
        run1("sFF",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0,         32'h0000_0001, 1'b0);
        run1("sm1x2", 32'hFFFF_FFFF, 32'd2,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run1("s8x8",  32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0,         1'b1);
        run1("s8x1",  32'h8000_0000, 32'd1,         1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        run1("zero",  32'd0,         32'h1234_5678, 1'b1, 32'h0,         32'h0,         1'b0);

        // Re-pulse with new operands mid-RUN must be ignored
        start_op(1'b0, 32'd7, 32'd9, 1'b0);
        a = 32'd1000; b = 32'd1000;
        repeat (5) @(posedge clk);
        check_eq("run_busy", 64'(busy1), 64'd1);
        start_op(1'b0, 32'd100, 32'd100, 1'b0);
        a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; is_signed = 1'b1;
        wait_done(1'b0, lat);
        check_eq("ign_lat", 64'(lat), 64'd27);
        check_eq("ign_prod", {hi1, lo1}, 64'd63);

        // Back-to-back: start request during the done cycle takes effect on its falling edge
        start_op(1'b0, 32'd3, 32'd4, 1'b0);
        check_eq("b2b_busy", 64'(busy1), 64'd1);
        check_eq("b2b_held", {hi1, lo1}, 64'd63);
        wait_done(1'b0, lat);
        check_eq("b2b_lat", 64'(lat), 64'd33);
        check_eq("b2b_prod", {hi1, lo1}, 64'd12);

        // Asynchronous reset at RUN cycle 10 aborts the operation
        start_op(1'b0, 32'h1234, 32'h5678, 1'b0);
        repeat (9) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("ar_out", {hi1, lo1}, 64'd0);
        check_eq("ar_flags", 64'({busy1, ovf1, done1}), 64'd0);
        seen_done = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done1 || busy1) seen_done++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done1 || busy1) seen_done++;
        end
        check_eq("ar_nodone", 64'(seen_done), 64'd0);
        run1("post_rst", 32'd3, 32'h69, 1'b0, 32'h0, 32'h13B, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
